board_eval: RTL

BOARD_EVAL -- requirements
Module: board_eval

---
 rtl/board_eval.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/board_eval.sv
// rtl/board_eval.sv - Chess board material evaluator with register and SDRAM ports
// Purpose: fetches n candidate boards (64 words each) from SDRAM one word at a
//          time, scores each board by material and keeps the best board index
//          and score. Best means highest score when side = 0, lowest when side = 1.
// Ports:
//    clk, rst_n       rising-edge clock, synchronous active-low reset
//    slave_*          CPU register port
//                     writes: 0 start, 1 src, 2 n[7:0], 3 side[0]
//                     reads:  0 best_idx, 1 best_score, others 0
//    master_*         SDRAM port, read-only, at most one read outstanding
module board_eval (
   input  logic        clk,
   input  logic        rst_n,
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   output logic [31:0] slave_readdata,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   input  logic        master_waitrequest,
   output logic [31:0] master_address,
   output logic        master_read,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid,
   output logic        master_write,
   output logic [31:0] master_writedata
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] ISSUE      = 3'd1;
   localparam logic [2:0] WAIT_DATA  = 3'd2;
   localparam logic [2:0] NEXT_BOARD = 3'd3;
   localparam logic [2:0] DONE       = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [31:0]        src_q, src_d;
   logic [7:0]         n_q, n_d;
   logic               side_q, side_d;
   logic [7:0]         b_q, b_d;
   logic [5:0]         s_q, s_d;
   logic signed [31:0] acc_q, acc_d;
   logic [31:0]        best_idx_q, best_idx_d;
   logic signed [31:0] best_score_q, best_score_d;

   logic               better;
   logic               unused_rdata;

   // Only the low byte of each square word carries the piece.
   assign unused_rdata = ^master_readdata[31:8];

   // Signed material value of one square; unknown magnitudes count as empty.
   function automatic logic signed [31:0] piece_value(input logic [7:0] p);
      logic [7:0]         mag;
      logic signed [31:0] v;
      mag = p[7] ? (~p + 8'd1) : p;
      case (mag)
         8'd1:    v = 32'sd100;
         8'd2:    v = 32'sd320;
         8'd3:    v = 32'sd330;
         8'd4:    v = 32'sd500;
         8'd5:    v = 32'sd900;
         8'd6:    v = 32'sd20000;
         default: v = 32'sd0;
      endcase
      return p[7] ? -v : v;
   endfunction

   // Square address src + 64*b + s: b and s concatenate into the word offset.
   assign master_address   = src_q + {18'd0, b_q, s_q};
   assign master_read      = (state_q == ISSUE);
   assign master_write     = 1'b0;
   assign master_writedata = 32'd0;

   // Busy during the run; also held high while reset is applied.
   assign slave_waitrequest = ~rst_n | (state_q == ISSUE) |
                              (state_q == WAIT_DATA) | (state_q == NEXT_BOARD);

   always_comb begin
      case (slave_address)
         4'd0:    slave_readdata = best_idx_q;
         4'd1:    slave_readdata = best_score_q;
         default: slave_readdata = 32'd0;
      endcase
   end

   // Strict comparison keeps the lower index on ties.
   assign better = side_q ? (acc_q < best_score_q) : (acc_q > best_score_q);

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      n_d          = n_q;
      side_d       = side_q;
      b_d          = b_q;
      s_d          = s_q;
      acc_d        = acc_q;
      best_idx_d   = best_idx_q;
      best_score_d = best_score_q;
      case (state_q)
         IDLE: begin
            if (slave_write) begin
               case (slave_address)
                  4'd0: begin
                     b_d          = 8'd0;
                     s_d          = 6'd0;
                     acc_d        = 32'sd0;
                     best_idx_d   = 32'hFFFF_FFFF;
                     best_score_d = 32'sd0;
                     state_d      = (n_q == 8'd0) ? DONE : ISSUE;
                  end
                  4'd1:    src_d  = slave_writedata;
                  4'd2:    n_d    = slave_writedata[7:0];
                  4'd3:    side_d = slave_writedata[0];
                  default: ;
               endcase
            end
         end
         ISSUE: begin
            if (!master_waitrequest) state_d = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (master_readdatavalid) begin
               acc_d = acc_q + piece_value(master_readdata[7:0]);
               if (s_q == 6'd63) begin
                  state_d = NEXT_BOARD;
               end else begin
                  s_d     = s_q + 6'd1;
                  state_d = ISSUE;
               end
            end
         end
         NEXT_BOARD: begin
            if (b_q == 8'd0 || better) begin
               best_idx_d   = {24'd0, b_q};
               best_score_d = acc_q;
            end
            b_d = b_q + 8'd1;
            if ((b_q + 8'd1) == n_q) begin
               state_d = DONE;
            end else begin
               s_d     = 6'd0;
               acc_d   = 32'sd0;
               state_d = ISSUE;
            end
         end
         DONE: begin
            if (slave_read && slave_address == 4'd0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         src_q        <= 32'd0;
         n_q          <= 8'd0;
         side_q       <= 1'b0;
         b_q          <= 8'd0;
         s_q          <= 6'd0;
         acc_q        <= 32'sd0;
         best_idx_q   <= 32'hFFFF_FFFF;
         best_score_q <= 32'sd0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         n_q          <= n_d;
         side_q       <= side_d;
         b_q          <= b_d;
         s_q          <= s_d;
         acc_q        <= acc_d;
         best_idx_q   <= best_idx_d;
         best_score_q <= best_score_d;
      end
   end

endmodule
